jtpang_objbuf: RTL and testbench

- Double-buffered object line buffer that produces the 8-bit obj_pxl stream consumed by the colour mixer, one pixel per pxl_cen.
- The sprite drawer writes pixels into the draw bank during line N. The scan bank is read out during line N+1, and each location is erased to 8'hFF as it is read.
- Low nibble F is transparent. The colour mixer treats obj_pxl[3:0]==4'hF as "show character layer".

---
 rtl/jtpang_objbuf.sv | 106 ++++++++++
 tb/tb_jtpang_objbuf.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/jtpang_objbuf.sv
// Double-buffered object line buffer. The drawer fills one 512-entry bank while the other
// bank is scanned out to the colour mixer and erased to transparent behind the read.
module jtpang_objbuf #(
  parameter logic [8:0]  HOFFSET = 9'd0,
  parameter int unsigned HSIZE   = 384
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen_i,
  input  logic       lhbl_i,
  input  logic       flip_i,
  input  logic       draw_we_i,
  input  logic [8:0] draw_x_i,
  input  logic [7:0] draw_pxl_i,
  output logic       line_swap_o,
  output logic [7:0] obj_pxl_o
);

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  state_e     state_q, state_d;
  logic       draw_bank_q, lhbl_q, line_swap_q;
  logic [8:0] rd_cnt_q, rd_cnt_d;
  logic [7:0] obj_pxl_q, obj_pxl_d;
  logic [7:0] scan_q;
  logic       swap, rd_go, erase_we, draw_wr;
  logic [9:0] draw_addr, scan_addr;
  logic [7:0] mem [1024];

  assign swap      = lhbl_q & ~lhbl_i;
  // Transparent pixels are skipped so lower-priority pixels already drawn survive.
  assign draw_wr   = draw_we_i && (draw_pxl_i[3:0] != 4'hF) && ({23'd0, draw_x_i} < HSIZE);
  // Both addresses use the pre-toggle bank, so a write on the swap clk lands in the old bank.
  assign draw_addr = {draw_bank_q, draw_x_i};
  assign scan_addr = {~draw_bank_q, rd_cnt_q};

  assign line_swap_o = line_swap_q;
  assign obj_pxl_o   = obj_pxl_q;

  // Scan FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Scan FSM next state: each accepted pixel enable costs exactly one READ clk
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pxl_cen_i && lhbl_i && !swap) state_d = StRead;
      StRead:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Scan FSM outputs: RAM read launch and the registered erase enable
  always_comb begin
    rd_go    = (state_q == StIdle) && pxl_cen_i && lhbl_i && !swap;
    erase_we = (state_q == StRead);
  end

  // Read counter and output pixel next state
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    obj_pxl_d = obj_pxl_q;
    if (swap) begin
      rd_cnt_d = HOFFSET;
    end else if (erase_we) begin
      rd_cnt_d = flip_i ? rd_cnt_q - 9'd1 : rd_cnt_q + 9'd1;
    end
    if (erase_we) begin
      obj_pxl_d = scan_q;
    end else if (pxl_cen_i && !lhbl_i) begin
      obj_pxl_d = 8'hFF;
    end
  end

  // Bank select, blank edge detector, swap pulse, read counter and output pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      draw_bank_q <= 1'b0;
      lhbl_q      <= 1'b1;
      line_swap_q <= 1'b0;
      rd_cnt_q    <= HOFFSET;
      obj_pxl_q   <= 8'hFF;
    end else begin
      draw_bank_q <= draw_bank_q ^ swap;
      lhbl_q      <= lhbl_i;
      line_swap_q <= swap;
      rd_cnt_q    <= rd_cnt_d;
      obj_pxl_q   <= obj_pxl_d;
    end
  end

  // Dual-port line RAM: port A draws, port B reads then erases the same entry
  always_ff @(posedge clk) begin
    if (draw_wr)  mem[draw_addr] <= draw_pxl_i;
    if (erase_we) mem[scan_addr] <= 8'hFF;
    if (rd_go)    scan_q <= mem[scan_addr];
  end

  // A pixel enable on the READ clk is dropped; the pixel source must keep them 2 clk apart.
  pxl_cen_spacing: assert property (@(posedge clk) disable iff (!rst_n)
    !(pxl_cen_i && state_q == StRead));

endmodule

// File: tb/tb_jtpang_objbuf.sv
// Directed bench for jtpang_objbuf: three instances share stimulus and differ in read offset
// and accepted width, so offset, flip and wrap cases can be observed in one run.
module tb_jtpang_objbuf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pxl_cen = 1'b0;
  logic       lhbl = 1'b1;
  logic       flip = 1'b0;
  logic       draw_we = 1'b0;
  logic [8:0] draw_x = 9'd0;
  logic [7:0] draw_pxl = 8'd0;
  logic       swap0, swap2, swap510;
  logic [7:0] obj0, obj2, obj510;
  logic [7:0] got0 [512];
  logic [7:0] got2 [512];
  logic [7:0] got510 [512];
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  jtpang_objbuf #(.HOFFSET(9'd0), .HSIZE(384)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pxl_cen_i(pxl_cen), .lhbl_i(lhbl), .flip_i(flip),
    .draw_we_i(draw_we), .draw_x_i(draw_x), .draw_pxl_i(draw_pxl),
    .line_swap_o(swap0), .obj_pxl_o(obj0)
  );

  jtpang_objbuf #(.HOFFSET(9'd2), .HSIZE(512)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .pxl_cen_i(pxl_cen), .lhbl_i(lhbl), .flip_i(flip),
    .draw_we_i(draw_we), .draw_x_i(draw_x), .draw_pxl_i(draw_pxl),
    .line_swap_o(swap2), .obj_pxl_o(obj2)
  );

  jtpang_objbuf #(.HOFFSET(9'd510), .HSIZE(512)) u_dut510 (
    .clk(clk), .rst_n(rst_n), .pxl_cen_i(pxl_cen), .lhbl_i(lhbl), .flip_i(flip),
    .draw_we_i(draw_we), .draw_x_i(draw_x), .draw_pxl_i(draw_pxl),
    .line_swap_o(swap510), .obj_pxl_o(obj510)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  // One pixel: enable for one clk, output is settled two negedges later.
  task automatic pxl_step();
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    @(negedge clk);
  endtask

  task automatic scan_line();
    for (int k = 0; k < 512; k++) begin
      pxl_step();
      got0[k]   = obj0;
      got2[k]   = obj2;
      got510[k] = obj510;
    end
  endtask

  task automatic draw(input logic [8:0] x, input logic [7:0] p);
    draw_we  = 1'b1;
    draw_x   = x;
    draw_pxl = p;
    @(negedge clk);
    draw_we  = 1'b0;
  endtask

  // Blanking interval; optionally a pixel enable and a draw (x=7, 8'h66) on the swap clk.
  task automatic hblank(input bit with_cen, input bit with_draw, input string tag);
    int pulses;
    pulses   = 0;
    lhbl     = 1'b0;
    pxl_cen  = with_cen;
    draw_we  = with_draw;
    draw_x   = 9'd7;
    draw_pxl = 8'h66;
    @(negedge clk);
    pxl_cen  = 1'b0;
    draw_we  = 1'b0;
    if (with_cen) check_eq({tag, "_cen_obj"}, 32'(obj510), 32'hFF);
    for (int i = 0; i < 4; i++) begin
      if (swap0) pulses++;
      if (swap2 !== swap0 || swap510 !== swap0) pulses += 10;
      @(negedge clk);
    end
    check_eq({tag, "_swap_pulses"}, pulses, 1);
    lhbl = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int bad;
    // Asynchronous reset, observed before any clock edge
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_obj", 32'(obj0), 32'hFF);
    check_eq("rst_swap", 32'(swap0), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Flush: read-erase both banks in every instance
    scan_line();
    hblank(1'b0, 1'b0, "hb1");
    scan_line();

    // Single line
    for (int i = 0; i < 4; i++) draw(9'(i), 8'(16 + i));
    hblank(1'b0, 1'b0, "hb2");
    scan_line();
    for (int i = 0; i < 4; i++) check_eq("s1_px", 32'(got0[i]), 32'(16 + i));
    bad = 0;
    for (int k = 4; k < 512; k++) if (got0[k] !== 8'hFF) bad++;
    check_eq("s1_rest_ff", bad, 0);

    // Transparency and priority
    draw(9'd5, 8'h27);
    draw(9'd5, 8'h3F);
    draw(9'd6, 8'h41);
    draw(9'd6, 8'h52);
    hblank(1'b0, 1'b0, "hb3");
    scan_line();
    check_eq("prio_x5", 32'(got0[5]), 32'h27);
    check_eq("prio_x6", 32'(got0[6]), 32'h52);

    // Bank of the single-line test comes back erased
    hblank(1'b0, 1'b0, "hb4");
    scan_line();
    bad = 0;
    for (int k = 0; k < 512; k++) if (got0[k] !== 8'hFF) bad++;
    check_eq("rescan_erased", bad, 0);

    // Width boundary
    draw(9'd383, 8'h02);
    draw(9'd384, 8'h01);
    hblank(1'b0, 1'b0, "hb5");
    scan_line();
    check_eq("hsize_last", 32'(got0[383]), 32'h02);
    check_eq("hsize_drop", 32'(got0[384]), 32'hFF);

    // Flip with offset 2, wrapping below zero
    draw(9'd2, 8'hA0);
    draw(9'd1, 8'hA1);
    draw(9'd0, 8'hA2);
    draw(9'd511, 8'hA3);
    draw(9'd510, 8'hA4);
    hblank(1'b0, 1'b0, "hb6");
    flip = 1'b1;
    scan_line();
    flip = 1'b0;
    for (int i = 0; i < 5; i++) check_eq("flip_px", 32'(got2[i]), 32'(8'hA0 + i));

    // Offset 510 counting up wraps past 511
    draw(9'd510, 8'hB0);
    draw(9'd511, 8'hB1);
    draw(9'd0, 8'hB2);
    draw(9'd509, 8'h5A);
    hblank(1'b0, 1'b0, "hb7");
    scan_line();
    check_eq("wrap_510", 32'(got510[0]), 32'hB0);
    check_eq("wrap_511", 32'(got510[1]), 32'hB1);
    check_eq("wrap_0", 32'(got510[2]), 32'hB2);
    check_eq("wrap_last", 32'(got510[511]), 32'h5A);

    // Draw and pixel enable on the swap clk
    hblank(1'b1, 1'b1, "hb8");
    scan_line();
    check_eq("coll_x7", 32'(got0[7]), 32'h66);
    check_eq("coll_x0_offset", 32'(got0[0]), 32'hFF);

    // Reset in the middle of a READ
    for (int i = 0; i < 4; i++) draw(9'(i), 8'(16 + i));
    hblank(1'b0, 1'b0, "hb9");
    pxl_step();
    check_eq("pre_rst_obj", 32'(obj0), 32'h10);
    pxl_cen = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_obj", 32'(obj0), 32'hFF);
    check_eq("mid_rst_bank", 32'(u_dut0.draw_bank_q), 32'h0);
    @(negedge clk);
    pxl_cen = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    hblank(1'b0, 1'b0, "hb10");
    scan_line();
    check_eq("post_rst_x0", 32'(got0[0]), 32'hFF);
    for (int i = 1; i < 4; i++) check_eq("post_rst_px", 32'(got0[i]), 32'(16 + i));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
